// File: rtl/traceback_unit.sv
// Viterbi traceback: walks back one trellis column per cycle from the best end state, then replays the bits oldest-first.
// Latency: first o_dec_vld N+1 cycles after the first TRACE cycle (N = columns consumed, 1..TB_DEPTH).
// Backpressure: none on the output; en_tb=0 freezes everything, o_dec_vld/o_tb_done read 0 while frozen.
//
// Ports:
//   clk, rst (async, active-low), en_tb (block enable)
//   i_td_full / i_td_empty : trellis memory has a full column set / is presenting its last column
//   i_min_st               : best end state, sampled on the start cycle
//   i_bck_prv_st[s]        : predecessor of state s in the column currently presented
//   o_tb_busy              : high while tracing; steps the trellis memory one column per cycle
//   o_dec_bit / o_dec_vld  : decoded bit stream, chronological order
//   o_bit_cnt              : bits produced by the last completed traceback
//   o_tb_done              : one-cycle pulse after the last decoded bit
module traceback_unit #(
    parameter int ST_W     = 8,
    parameter int NUM_ST   = 256,
    parameter int TB_DEPTH = 45,
    parameter int CNT_W    = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_tb,
    input  logic             i_td_full,
    input  logic             i_td_empty,
    input  logic [ST_W-1:0]  i_min_st,
    input  logic [ST_W-1:0]  i_bck_prv_st [NUM_ST],
    output logic             o_tb_busy,
    output logic             o_dec_bit,
    output logic             o_dec_vld,
    output logic [CNT_W-1:0] o_bit_cnt,
    output logic             o_tb_done
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_TRACE  = 2'd1;
    localparam logic [1:0] S_OUTPUT = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    localparam logic [CNT_W-1:0] DEPTH_M1 = CNT_W'(TB_DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [1:0]          state;
    logic [ST_W-1:0]     cur_st;
    logic [CNT_W-1:0]    col_cnt;
    logic [CNT_W-1:0]    ptr;
    logic [TB_DEPTH-1:0] lifo;

    logic [ST_W-1:0]     prv_st;
    logic                last_col;

    // cur_st is registered, so the feedback loop is just this 256:1 mux.
    assign prv_st = i_bck_prv_st[cur_st];

    // Depth limit and memory-empty can coincide; either way we leave TRACE once,
    // and the column presented this cycle is still consumed.
    assign last_col = (col_cnt == DEPTH_M1) || i_td_empty;

    assign o_tb_busy = (state == S_TRACE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            cur_st    <= '0;
            col_cnt   <= '0;
            ptr       <= '0;
            lifo      <= '0;
            o_dec_bit <= 1'b0;
            o_dec_vld <= 1'b0;
            o_bit_cnt <= '0;
            o_tb_done <= 1'b0;
        end else begin
            // Pulse-type outputs default low, including every frozen cycle.
            o_dec_vld <= 1'b0;
            o_tb_done <= 1'b0;
            if (en_tb) begin
                case (state)
                    S_IDLE: begin
                        if (i_td_full) begin
                            cur_st  <= i_min_st;
                            col_cnt <= '0;
                            state   <= S_TRACE;
                        end
                    end
                    S_TRACE: begin
                        // Encoder shifts the input bit into the MSB, so the MSB
                        // of the state reached is the bit decoded for this column.
                        lifo[ptr] <= cur_st[ST_W-1];
                        ptr       <= ptr + CNT_ONE;
                        cur_st    <= prv_st;
                        col_cnt   <= col_cnt + CNT_ONE;
                        if (last_col) begin
                            o_bit_cnt <= col_cnt + CNT_ONE;
                            state     <= S_OUTPUT;
                        end
                    end
                    S_OUTPUT: begin
                        // Traceback walked backwards in time; popping restores order.
                        o_dec_vld <= 1'b1;
                        o_dec_bit <= lifo[ptr - CNT_ONE];
                        ptr       <= ptr - CNT_ONE;
                        if (ptr == CNT_ONE) begin
                            state <= S_DONE;
                        end
                    end
                    default: begin
                        o_tb_done <= 1'b1;
                        ptr       <= '0;
                        state     <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_traceback_unit.sv
module tb_traceback_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic       en_tb;
    logic       i_td_full;
    logic       i_td_empty;
    logic [7:0] i_min_st;
    logic [7:0] bck [256];
    logic       o_tb_busy;
    logic       o_dec_bit;
    logic       o_dec_vld;
    logic [5:0] o_bit_cnt;
    logic       o_tb_done;

    always #5 clk = ~clk;

    traceback_unit dut (
        .clk          (clk),
        .rst          (rst),
        .en_tb        (en_tb),
        .i_td_full    (i_td_full),
        .i_td_empty   (i_td_empty),
        .i_min_st     (i_min_st),
        .i_bck_prv_st (bck),
        .o_tb_busy    (o_tb_busy),
        .o_dec_bit    (o_dec_bit),
        .o_dec_vld    (o_dec_vld),
        .o_bit_cnt    (o_bit_cnt),
        .o_tb_done    (o_tb_done)
    );

    int   n_chk  = 0;
    int   n_fail = 0;

    // Results of the last run_trace call.
    logic got_bits [64];
    int   got_n;
    int   done_n;
    int   first_busy;
    int   first_vld;
    int   last_vld;
    int   done_cyc;
    int   stall_vld_bad;
    int   late_busy;
    int   late_vld;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // mode 0: every predecessor is state 0; mode 1: predecessor = rotate-left(s).
    task automatic set_table(input int mode);
        for (int s = 0; s < 256; s++) begin
            if (mode == 0) bck[s] = 8'h00;
            else           bck[s] = 8'({s[6:0], s[7]});
        end
    endtask

    // Starts one traceback from IDLE and observes it to completion.
    // empty_at: trace column (1-based) on which i_td_empty is raised, -1 none.
    // stall_tr_at / stall_out_at: drop en_tb 3 cycles at that column / 2 cycles after that many bits.
    // full_at: pulse i_td_full once after that many output bits.
    task automatic run_trace(input logic [7:0] start, input int empty_at,
                             input int stall_tr_at, input int stall_out_at, input int full_at);
        int  tr_n       = 0;
        int  stall_left = 0;
        bit  tr_st      = 0;
        bit  out_st     = 0;
        bit  full_fired = 0;
        bit  prev_en    = 1;
        bit  seen_done  = 0;
        int  tail       = 0;
        got_n = 0; done_n = 0; first_busy = -1; first_vld = -1; last_vld = -1;
        done_cyc = -1; stall_vld_bad = 0; late_busy = 0; late_vld = 0;
        i_min_st   = start;
        i_td_full  = 1'b1;
        i_td_empty = 1'b0;
        en_tb      = 1'b1;
        tick();
        i_td_full = 1'b0;
        i_min_st  = 8'h5A;   // start state must have been captured already
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (o_tb_busy && first_busy < 0) first_busy = cyc;
            if (o_tb_busy && seen_done) late_busy++;
            if (!prev_en && o_dec_vld) stall_vld_bad++;
            if (o_dec_vld) begin
                if (seen_done) late_vld++;
                if (got_n < 64) got_bits[got_n] = o_dec_bit;
                got_n++;
                if (first_vld < 0) first_vld = cyc;
                last_vld = cyc;
            end
            if (o_tb_done) begin
                done_n++;
                if (done_cyc < 0) done_cyc = cyc;
                seen_done = 1;
            end
            if (seen_done) begin
                tail++;
                if (tail > 6) break;
            end
            i_td_full  = 1'b0;
            i_td_empty = 1'b0;
            en_tb      = 1'b1;
            if (o_tb_busy && tr_n == stall_tr_at && !tr_st) begin
                tr_st = 1; stall_left = 3;
            end
            if (o_dec_vld && got_n == stall_out_at && !out_st) begin
                out_st = 1; stall_left = 2;
            end
            if (stall_left > 0) begin
                en_tb = 1'b0;
                stall_left--;
            end
            if (o_dec_vld && got_n == full_at && !full_fired) begin
                i_td_full  = 1'b1;
                full_fired = 1;
            end
            if (en_tb && o_tb_busy) begin
                if (tr_n + 1 == empty_at) i_td_empty = 1'b1;
                tr_n++;
            end
            prev_en = en_tb;
            tick();
        end
        i_td_full  = 1'b0;
        i_td_empty = 1'b0;
        en_tb      = 1'b1;
    endtask

    // Compares collected bits with: mode 0 all zero, mode 1 ones where j%8==4,
    // mode 2 ones at j==1 and j==9.
    task automatic check_bits(input string name, input int mode, input int n);
        int bad   = -1;
        logic exp = 1'b0;
        for (int j = 0; j < n && j < 64; j++) begin
            case (mode)
                1:       exp = ((j % 8) == 4);
                2:       exp = (j == 1 || j == 9);
                default: exp = 1'b0;
            endcase
            if (bad < 0 && got_bits[j] !== exp) bad = j;
        end
        n_chk++;
        if (bad >= 0) begin
            n_fail++;
            $display("FAIL %s bit sequence: first wrong index %0d, got %0b", name, bad, got_bits[bad]);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; en_tb = 1'b0; i_td_full = 1'b0; i_td_empty = 1'b0; i_min_st = 8'h00;
        set_table(0);
        #2 rst = 1'b0;
        #3;
        n_chk++; if (o_tb_busy !== 1'b0) begin n_fail++; $display("FAIL reset busy: got %b want 0", o_tb_busy); end
        n_chk++; if (o_dec_vld !== 1'b0) begin n_fail++; $display("FAIL reset vld: got %b want 0", o_dec_vld); end
        n_chk++; if (o_dec_bit !== 1'b0) begin n_fail++; $display("FAIL reset bit: got %b want 0", o_dec_bit); end
        n_chk++; if (o_bit_cnt !== 6'd0) begin n_fail++; $display("FAIL reset bit_cnt: got %0d want 0", o_bit_cnt); end
        n_chk++; if (o_tb_done !== 1'b0) begin n_fail++; $display("FAIL reset done: got %b want 0", o_tb_done); end
        tick(); tick();
        rst = 1'b1;
        en_tb = 1'b1;
        tick();
    endtask

    task automatic test_all_zero();
        set_table(0);
        run_trace(8'h00, -1, -1, -1, -1);
        n_chk++; if (got_n !== 45) begin n_fail++; $display("FAIL zero count: got %0d want 45", got_n); end
        check_bits("zero", 0, 45);
        n_chk++; if (o_bit_cnt !== 6'd45) begin n_fail++; $display("FAIL zero bit_cnt: got %0d want 45", o_bit_cnt); end
        n_chk++; if (done_n !== 1) begin n_fail++; $display("FAIL zero done pulses: got %0d want 1", done_n); end
        n_chk++; if (first_vld - first_busy !== 46) begin n_fail++; $display("FAIL zero latency: got %0d want 46", first_vld - first_busy); end
        n_chk++; if (last_vld - first_vld !== 44) begin n_fail++; $display("FAIL zero contiguous output: got span %0d want 44", last_vld - first_vld); end
        n_chk++; if (done_cyc - last_vld !== 1) begin n_fail++; $display("FAIL zero done timing: got %0d want 1", done_cyc - last_vld); end
    endtask

    task automatic test_rotating();
        set_table(1);
        run_trace(8'h80, -1, -1, -1, -1);
        n_chk++; if (got_n !== 45) begin n_fail++; $display("FAIL rot count: got %0d want 45", got_n); end
        check_bits("rot", 1, 45);
        n_chk++; if (o_bit_cnt !== 6'd45) begin n_fail++; $display("FAIL rot bit_cnt: got %0d want 45", o_bit_cnt); end
    endtask

    task automatic test_early_end();
        set_table(1);
        run_trace(8'h80, 10, -1, -1, -1);
        n_chk++; if (got_n !== 10) begin n_fail++; $display("FAIL early count: got %0d want 10", got_n); end
        check_bits("early", 2, 10);
        n_chk++; if (o_bit_cnt !== 6'd10) begin n_fail++; $display("FAIL early bit_cnt: got %0d want 10", o_bit_cnt); end
        n_chk++; if (first_vld - first_busy !== 11) begin n_fail++; $display("FAIL early latency: got %0d want 11", first_vld - first_busy); end
        n_chk++; if (done_cyc - last_vld !== 1) begin n_fail++; $display("FAIL early done timing: got %0d want 1", done_cyc - last_vld); end
        // Empty on the 45th column coincides with the depth limit: single exit, 45 bits.
        run_trace(8'h80, 45, -1, -1, -1);
        n_chk++; if (got_n !== 45) begin n_fail++; $display("FAIL both-exit count: got %0d want 45", got_n); end
        n_chk++; if (o_bit_cnt !== 6'd45) begin n_fail++; $display("FAIL both-exit bit_cnt: got %0d want 45", o_bit_cnt); end
        n_chk++; if (done_n !== 1) begin n_fail++; $display("FAIL both-exit done pulses: got %0d want 1", done_n); end
    endtask

    task automatic test_stall();
        set_table(1);
        run_trace(8'h80, -1, 20, 20, -1);
        n_chk++; if (got_n !== 45) begin n_fail++; $display("FAIL stall count: got %0d want 45", got_n); end
        check_bits("stall", 1, 45);
        n_chk++; if (stall_vld_bad !== 0) begin n_fail++; $display("FAIL stall vld while frozen: got %0d want 0", stall_vld_bad); end
        n_chk++; if (first_vld - first_busy !== 49) begin n_fail++; $display("FAIL stall latency: got %0d want 49", first_vld - first_busy); end
    endtask

    task automatic test_ignored_start();
        set_table(0);
        run_trace(8'h00, -1, -1, -1, 10);
        n_chk++; if (got_n !== 45) begin n_fail++; $display("FAIL ignstart count: got %0d want 45", got_n); end
        n_chk++; if (late_busy !== 0) begin n_fail++; $display("FAIL ignstart restart after done: got %0d busy cycles want 0", late_busy); end
        n_chk++; if (late_vld !== 0) begin n_fail++; $display("FAIL ignstart extra bits: got %0d want 0", late_vld); end
        run_trace(8'h00, 5, -1, -1, -1);
        n_chk++; if (got_n !== 5) begin n_fail++; $display("FAIL ignstart next run count: got %0d want 5", got_n); end
    endtask

    task automatic test_reset_mid_trace();
        int busy_n = 0;
        int vld_n  = 0;
        set_table(1);
        i_min_st  = 8'h80;
        i_td_full = 1'b1;
        tick();
        i_td_full = 1'b0;
        repeat (5) tick();
        n_chk++; if (o_tb_busy !== 1'b1) begin n_fail++; $display("FAIL midrst pre busy: got %b want 1", o_tb_busy); end
        rst = 1'b0;
        #1;
        n_chk++; if (o_tb_busy !== 1'b0) begin n_fail++; $display("FAIL midrst busy: got %b want 0", o_tb_busy); end
        n_chk++; if (o_bit_cnt !== 6'd0) begin n_fail++; $display("FAIL midrst bit_cnt: got %0d want 0", o_bit_cnt); end
        tick();
        rst = 1'b1;
        for (int c = 0; c < 120; c++) begin
            if (o_tb_busy) busy_n++;
            if (o_dec_vld) vld_n++;
            tick();
        end
        n_chk++; if (vld_n !== 0) begin n_fail++; $display("FAIL midrst bits after reset: got %0d want 0", vld_n); end
        n_chk++; if (busy_n !== 0) begin n_fail++; $display("FAIL midrst busy after reset: got %0d want 0", busy_n); end
    endtask

    initial begin
        test_reset();
        test_all_zero();
        test_rotating();
        test_early_end();
        test_stall();
        test_ignored_start();
        test_reset_mid_trace();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
